// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: state encoding,
// control-word bit positions and the default program counter width.
package seq_pkg;

    localparam int PC_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FETCH  = 2'd1,
        ST_DECODE = 2'd2,
        ST_EXEC   = 2'd3
    } state_t;

    // ctl = {we, beq, bne, bge, blt, jmp, jmpr}
    localparam int CTL_W    = 7;
    localparam int CTL_WE   = 6;
    localparam int CTL_BEQ  = 5;
    localparam int CTL_BNE  = 4;
    localparam int CTL_BGE  = 3;
    localparam int CTL_BLT  = 2;
    localparam int CTL_JMP  = 1;
    localparam int CTL_JMPR = 0;

endpackage

// File: rtl/next_pc_sel.sv
// Combinational next-PC selection: register jump, immediate jump or taken
// branch, otherwise sequential increment (wrapping at 2^PC_W).
module next_pc_sel
    import seq_pkg::*;
#(
    parameter int PC_W = PC_W_DEFAULT
) (
    input  logic [PC_W-1:0]   pc,
    input  logic [CTL_BEQ:0]  br_ctl,
    input  logic              alu_zero,
    input  logic              alu_neg,
    input  logic [PC_W-1:0]   target,
    input  logic [PC_W-1:0]   rs_val,
    output logic [PC_W-1:0]   next_pc,
    output logic [PC_W-1:0]   pc_inc
);

    logic taken;

    assign pc_inc = pc + PC_W'(1);

    assign taken = (br_ctl[CTL_BEQ] &  alu_zero) |
                   (br_ctl[CTL_BNE] & ~alu_zero) |
                   (br_ctl[CTL_BGE] & ~alu_neg)  |
                   (br_ctl[CTL_BLT] &  alu_neg);

    always_comb begin
        next_pc = pc_inc;
        if (br_ctl[CTL_JMPR]) begin
            next_pc = rs_val;
        end else if (br_ctl[CTL_JMP] || taken) begin
            next_pc = target;
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Four-state instruction sequencer (IDLE/FETCH/DECODE/EXEC) owning the
// program counter; the next-PC choice is delegated to next_pc_sel.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int PC_W = PC_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    output logic              imem_req,
    input  logic              imem_ack,
    output logic              ir_load,
    input  logic [CTL_W-1:0]  ctl,
    input  logic              alu_zero,
    input  logic              alu_neg,
    input  logic [PC_W-1:0]   target,
    input  logic [PC_W-1:0]   rs_val,
    output logic [PC_W-1:0]   pc,
    output logic              rf_we,
    output logic [PC_W-1:0]   link_pc,
    output logic              busy
);

    localparam logic [1:0] IDLE   = ST_IDLE;
    localparam logic [1:0] FETCH  = ST_FETCH;
    localparam logic [1:0] DECODE = ST_DECODE;
    localparam logic [1:0] EXEC   = ST_EXEC;

    logic [1:0]      state_reg;
    logic [1:0]      state_next;
    logic [PC_W-1:0] pc_reg;
    logic [PC_W-1:0] next_pc;
    logic [PC_W-1:0] pc_inc;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (run) state_next = FETCH;
            FETCH:   if (imem_ack) state_next = DECODE;
            DECODE:  state_next = EXEC;
            EXEC:    state_next = run ? FETCH : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // An in-flight fetch is simply dropped by reset; nothing is remembered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            pc_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == EXEC) begin
                pc_reg <= next_pc;
            end
        end
    end

    next_pc_sel #(
        .PC_W (PC_W)
    ) u_next_pc_sel (
        .pc       (pc_reg),
        .br_ctl   (ctl[CTL_BEQ:0]),
        .alu_zero (alu_zero),
        .alu_neg  (alu_neg),
        .target   (target),
        .rs_val   (rs_val),
        .next_pc  (next_pc),
        .pc_inc   (pc_inc)
    );

    // Strobes decode straight from state so reset clears them without a clock.
    assign imem_req = (state_reg == FETCH);
    assign ir_load  = (state_reg == FETCH) && imem_ack;
    assign rf_we    = (state_reg == EXEC) && ctl[CTL_WE];
    assign busy     = (state_reg != IDLE);
    assign pc       = pc_reg;
    assign link_pc  = pc_inc;

endmodule
